// File: rtl/j_result_collector.sv
// Per-row partial-sum collector: accumulates NUM_PASSES sums per row, then drains
// shifted/saturated 16-bit results over valid/ready. Optional macro: RELU_COLLECT_EN.
module j_result_collector #(
  parameter int SUBARRAY_HEIGHT = 2,
  parameter int NUM_PASSES      = 4,
  parameter int ACC_WIDTH       = 24,
  parameter int OUT_SHIFT       = 0,
  parameter int ROW_IDX_WIDTH   = (SUBARRAY_HEIGHT > 1) ? $clog2(SUBARRAY_HEIGHT) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [16*SUBARRAY_HEIGHT-1:0] result,
  input  logic [SUBARRAY_HEIGHT-1:0]   result_en,
  output logic [15:0]                  out_data,
  output logic [ROW_IDX_WIDTH-1:0]     out_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         drop_err
);

  // Stream contract: out_data/out_row are held while out_valid && !out_ready;
  // a beat transfers on the rising edge where out_valid && out_ready.
  localparam int CNT_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32768);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc [SUBARRAY_HEIGHT];
  logic signed [ACC_WIDTH-1:0] ext [SUBARRAY_HEIGHT];
  logic [CNT_W-1:0]            cnt [SUBARRAY_HEIGHT];
  logic [SUBARRAY_HEIGHT-1:0]  done;
  logic [SUBARRAY_HEIGHT-1:0]  clear;
  logic [SUBARRAY_HEIGHT-1:0]  take;
  logic [SUBARRAY_HEIGHT-1:0]  drop;
  logic [ROW_IDX_WIDTH-1:0]    ptr;
  logic [ROW_IDX_WIDTH-1:0]    ptr_nxt;
  logic                        hs;

  function automatic logic [15:0] shape(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] s;
    logic [15:0]                 r;
    s = a >>> OUT_SHIFT;
    if (s > SAT_MAX)      r = 16'h7fff;
    else if (s < SAT_MIN) r = 16'h8000;
    else                  r = s[15:0];
`ifdef RELU_COLLECT_EN
    if (r[15]) r = '0;
`endif
    return r;
  endfunction

  // A row being drained this cycle may take a new sum as pass 0 of the next tile.
  always_comb begin
    hs      = (state == DRAIN) && out_valid && out_ready;
    ptr_nxt = ptr + ROW_IDX_WIDTH'(1);
    clear   = '0;
    take    = '0;
    drop    = '0;
    for (int j = 0; j < SUBARRAY_HEIGHT; j++) begin
      ext[j]   = ACC_WIDTH'(signed'(result[16*j +: 16]));
      clear[j] = hs && (ptr == ROW_IDX_WIDTH'(j));
      take[j]  = result_en[j] && (!done[j] || clear[j]);
      drop[j]  = result_en[j] && done[j] && !clear[j];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      out_data  <= '0;
      out_row   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      drop_err  <= 1'b0;
      done      <= '0;
      for (int j = 0; j < SUBARRAY_HEIGHT; j++) begin
        acc[j] <= '0;
        cnt[j] <= '0;
      end
    end else begin
      for (int j = 0; j < SUBARRAY_HEIGHT; j++) begin
        if (clear[j]) done[j] <= 1'b0;
        if (take[j]) begin
          acc[j] <= (cnt[j] == '0) ? ext[j] : acc[j] + ext[j];
          if (cnt[j] == CNT_W'(NUM_PASSES - 1)) begin
            cnt[j]  <= '0;
            done[j] <= 1'b1;
          end else begin
            cnt[j] <= cnt[j] + CNT_W'(1);
          end
        end
      end
      if (|drop) drop_err <= 1'b1;

      case (state)
        IDLE: begin
          if (&done) begin
            state     <= DRAIN;
            ptr       <= '0;
            out_row   <= '0;
            out_data  <= shape(acc[0]);
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        DRAIN: begin
          if (hs) begin
            if (ptr == ROW_IDX_WIDTH'(SUBARRAY_HEIGHT - 1)) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end else begin
              ptr      <= ptr_nxt;
              out_row  <= ptr_nxt;
              out_data <= shape(acc[ptr_nxt]);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_j_result_collector.sv
// Bench for j_result_collector: directed cases plus randomized tiles scored
// against a per-row sum/shift/saturate model.
module tb_j_result_collector;
  localparam int H  = 2;
  localparam int NP = 4;
  localparam int RW = 1;
  localparam int W  = 16 + RW;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   result;
  logic [1:0]    result_en;
  logic [15:0]   out_data, s_data;
  logic [RW-1:0] out_row, s_row;
  logic          out_valid, out_ready, busy, drop_err;
  logic          s_valid, s_busy, s_drop;

  int            total = 0;
  int            bad = 0;
  logic          sb_on = 1'b0;
  logic          rnd_ready = 1'b0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  sb_e;

  int            vals[2][NP];
  longint        tot[2];
  int            idx[2];
  logic [1:0]    fire;
  logic [15:0]   r0, r1;
  int            n;

  always #5 clk = ~clk;

  j_result_collector #(.SUBARRAY_HEIGHT(H), .NUM_PASSES(NP), .ACC_WIDTH(24), .OUT_SHIFT(0)) dut (
    .clk(clk), .reset(reset), .result(result), .result_en(result_en),
    .out_data(out_data), .out_row(out_row), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .drop_err(drop_err));

  j_result_collector #(.SUBARRAY_HEIGHT(H), .NUM_PASSES(NP), .ACC_WIDTH(24), .OUT_SHIFT(2)) dut_s (
    .clk(clk), .reset(reset), .result(result), .result_en(result_en),
    .out_data(s_data), .out_row(s_row), .out_valid(s_valid),
    .out_ready(1'b1), .busy(s_busy), .drop_err(s_drop));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_out(input longint sum, input int sh);
    longint v;
    v = sum >>> sh;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`ifdef RELU_COLLECT_EN
    if (v < 0) v = 0;
`endif
    return v[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic drive(input logic [1:0] en, input logic [15:0] a, input logic [15:0] b);
    result    = {b, a};
    result_en = en;
    step();
    result_en = 2'b00;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    result_en = 2'b00;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    chk(tag, {31'b0, out_valid}, 32'd1);
  endtask

  task automatic tile_a();
    drive(2'b01, 16'd100, 16'd0);
    drive(2'b11, 16'd200, 16'd1);
    drive(2'b11, -16'sd50, 16'd2);
    drive(2'b11, 16'd10, 16'd3);
    drive(2'b10, 16'd0, 16'd4);
  endtask

  // Scoreboard: every accepted beat must match the oldest expected {row, data}.
  always @(negedge clk) begin
    if (sb_on && !reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_row", {31'b0, out_row}, {31'b0, sb_e[W-1:16]});
        chk("sb_data", {16'b0, out_data}, {16'b0, sb_e[15:0]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_ready = 1'b1;
    result    = 32'h0009_0007;
    result_en = 2'b11;
    reset     = 1'b1;
    step(); step(); step();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", {16'b0, out_data}, 32'd0);
    chk("rst_row", {31'b0, out_row}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_drop", {31'b0, drop_err}, 32'd0);
    reset     = 1'b0;
    result_en = 2'b00;

    // Accumulate and drain with ready held high.
    tile_a();
    chk("acc_early", {31'b0, out_valid}, 32'd0);
    step();
    chk("acc_valid0", {31'b0, out_valid}, 32'd1);
    chk("acc_busy", {31'b0, busy}, 32'd1);
    chk("acc_row0", {31'b0, out_row}, 32'd0);
    chk("acc_data0", {16'b0, out_data}, 32'd260);
    step();
    chk("acc_valid1", {31'b0, out_valid}, 32'd1);
    chk("acc_row1", {31'b0, out_row}, 32'd1);
    chk("acc_data1", {16'b0, out_data}, 32'd10);
    step();
    chk("acc_idle", {31'b0, out_valid}, 32'd0);
    chk("acc_idle_busy", {31'b0, busy}, 32'd0);

    // Backpressure.
    out_ready = 1'b0;
    tile_a();
    step();
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_row", {31'b0, out_row}, 32'd0);
      chk("bp_data", {16'b0, out_data}, 32'd260);
      step();
    end
    out_ready = 1'b1;
    chk("bp_hold", {16'b0, out_data}, 32'd260);
    step();
    chk("bp_row1", {31'b0, out_row}, 32'd1);
    chk("bp_data1", {16'b0, out_data}, 32'd10);
    step();
    chk("bp_idle", {31'b0, out_valid}, 32'd0);

    // Saturation both ways, then OUT_SHIFT=2 on the second instance.
    do_reset();
    for (int i = 0; i < 4; i++) drive(2'b11, 16'd16000, -16'sd20000);
    step();
    chk("sat_pos", {16'b0, out_data}, 32'h7fff);
    step();
    chk("sat_neg", {16'b0, out_data}, 32'h8000);
    step();
    do_reset();
    for (int i = 0; i < 4; i++) drive(2'b11, 16'd1000, 16'd1000);
    step();
    chk("shift_valid", {31'b0, s_valid}, 32'd1);
    chk("shift_row0", {31'b0, s_row}, 32'd0);
    chk("shift_data0", {16'b0, s_data}, 32'd1000);
    chk("noshift_data0", {16'b0, out_data}, 32'd4000);
    step();
    chk("shift_data1", {16'b0, s_data}, 32'd1000);
    step();

    // Drop after completion, then same-cycle reuse on handshake.
    do_reset();
    out_ready = 1'b0;
    drive(2'b11, 16'd1, 16'd5);
    drive(2'b11, 16'd2, 16'd5);
    drive(2'b11, 16'd3, 16'd5);
    drive(2'b01, 16'd4, 16'd0);
    chk("drop_none", {31'b0, drop_err}, 32'd0);
    drive(2'b01, 16'd7, 16'd0);
    chk("drop_flag", {31'b0, drop_err}, 32'd1);
    drive(2'b10, 16'd0, 16'd5);
    step();
    chk("drop_valid", {31'b0, out_valid}, 32'd1);
    chk("drop_keep", {16'b0, out_data}, 32'd10);
    out_ready = 1'b1;
    drive(2'b01, 16'd5, 16'd0);
    chk("reuse_row1", {31'b0, out_row}, 32'd1);
    chk("reuse_data1", {16'b0, out_data}, 32'd20);
    step();
    chk("reuse_idle", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) drive(2'b11, 16'd1, 16'd2);
    drive(2'b10, 16'd0, 16'd2);
    wait_valid("reuse_to");
    chk("reuse_sum", {16'b0, out_data}, 32'd8);
    chk("drop_sticky", {31'b0, drop_err}, 32'd1);
    step();
    chk("reuse_row1b", {16'b0, out_data}, 32'd8);
    step();

    // Randomized tiles with random ready, scored against the model.
    do_reset();
    sb_on     = 1'b1;
    rnd_ready = 1'b1;
    for (int t = 0; t < 30; t++) begin
      for (int j = 0; j < H; j++) begin
        tot[j] = 0;
        idx[j] = 0;
        for (int p = 0; p < NP; p++) begin
          if ($urandom_range(0, 3) == 0) vals[j][p] = int'($urandom_range(0, 65535)) - 32768;
          else                           vals[j][p] = int'($urandom_range(0, 2000)) - 1000;
          tot[j] += vals[j][p];
        end
        exp_q.push_back({RW'(j), model_out(tot[j], 0)});
      end
      while (idx[0] < NP || idx[1] < NP) begin
        fire = 2'b00;
        r0   = 16'h0;
        r1   = 16'h0;
        if (idx[0] < NP && $urandom_range(0, 1) == 1) begin
          fire[0] = 1'b1;
          r0 = vals[0][idx[0]][15:0];
          idx[0]++;
        end
        if (idx[1] < NP && $urandom_range(0, 1) == 1) begin
          fire[1] = 1'b1;
          r1 = vals[1][idx[1]][15:0];
          idx[1]++;
        end
        drive(fire, r0, r1);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        step();
        n++;
      end
      chk("rnd_drain", 32'(exp_q.size()), 32'd0);
    end
    chk("rnd_drop", {31'b0, drop_err}, 32'd0);
    sb_on     = 1'b0;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();

    // Negative row total, then reset while stalled in drain.
    do_reset();
    out_ready = 1'b0;
    drive(2'b11, -16'sd5, 16'd1);
    for (int i = 0; i < 3; i++) drive(2'b11, 16'd0, 16'd1);
    step();
    chk("neg_valid", {31'b0, out_valid}, 32'd1);
`ifdef RELU_COLLECT_EN
    chk("neg_data", {16'b0, out_data}, 32'h0000);
`else
    chk("neg_data", {16'b0, out_data}, 32'hfffb);
`endif
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_data", {16'b0, out_data}, 32'd0);
    reset = 1'b0;
    step();
    chk("mid_rst_idle", {31'b0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
